// File: rtl/tot_event_pkg.sv
// rtl/tot_event_pkg.sv - shared types for the ToT event capture block
// FSM state encoding, default event record layout and drop counter width.
package tot_event_pkg;

  localparam int TOT_TS_WIDTH   = 16;
  localparam int DROP_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    WAIT_FALL
  } tot_state_e;

  typedef struct packed {
    logic                    sat;
    logic [TOT_TS_WIDTH-1:0] tot;
    logic [TOT_TS_WIDTH-1:0] timestamp;
  } tot_event_t;

endpackage

// File: rtl/tot_event_fifo.sv
// rtl/tot_event_fifo.sv - show-ahead event FIFO
// Head entry is visible on rdata whenever the FIFO is not empty; a push into a full FIFO is accepted when a pop happens in the same cycle.
module tot_event_fifo
  import tot_event_pkg::*;
#(
  parameter type T     = tot_event_t,
  parameter int  DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign level   = level_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: rdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tot_event_capture.sv
// rtl/tot_event_capture.sv - time-over-threshold measurement with timestamped event buffer
// Optional macro TOT_EVENT_TIMEOUT_EN: push a saturated event as soon as ToT hits its maximum, then wait for the falling edge.
module tot_event_capture
  import tot_event_pkg::*;
#(
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          ts_clear,
  input  logic                          rising_edge,
  input  logic                          falling_edge,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [TS_WIDTH-1:0]           ev_timestamp,
  output logic [TS_WIDTH-1:0]           ev_tot,
  output logic                          ev_sat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count
);

  localparam logic [TS_WIDTH-1:0] TS_MAX = '1;

  typedef struct packed {
    logic                sat;
    logic [TS_WIDTH-1:0] tot;
    logic [TS_WIDTH-1:0] timestamp;
  } ev_t;

  tot_state_e                state_q, state_d;
  logic [TS_WIDTH-1:0]       ts_q, ts_d;
  logic [TS_WIDTH-1:0]       cnt_q, cnt_d;
  logic [TS_WIDTH-1:0]       start_q, start_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      rise_only, fall_only;
  logic                      push, pop, fifo_full, fifo_empty;
  ev_t                       push_data, head;

  assign rise_only = rising_edge & ~falling_edge;
  assign fall_only = falling_edge & ~rising_edge;
  assign ev_valid  = ~fifo_empty;
  assign pop       = ev_valid & ev_ready;

  assign ts_d = ts_clear ? '0 : ts_q + 1'b1;

  // cnt_q equals cycles elapsed since the rising edge, so the value read
  // on the falling cycle is f - r directly.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    start_d             = start_q;
    push                = 1'b0;
    push_data.sat       = (cnt_q == TS_MAX);
    push_data.tot       = cnt_q;
    push_data.timestamp = start_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_only) begin
            start_d = ts_q;
            cnt_d   = {{(TS_WIDTH-1){1'b0}}, 1'b1};
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (cnt_q != TS_MAX) cnt_d = cnt_q + 1'b1;
`ifdef TOT_EVENT_TIMEOUT_EN
          if (cnt_q == TS_MAX) begin
            push    = 1'b1;
            state_d = fall_only ? IDLE : WAIT_FALL;
          end else if (fall_only) begin
            push    = 1'b1;
            state_d = IDLE;
          end
`else
          if (fall_only) begin
            push    = 1'b1;
            state_d = IDLE;
          end
`endif
        end
`ifdef TOT_EVENT_TIMEOUT_EN
        WAIT_FALL: begin
          if (fall_only) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (push && fifo_full && !pop && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ts_q    <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      drop_q  <= drop_d;
    end
  end

  tot_event_fifo #(
    .T     (ev_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_timestamp = head.timestamp;
  assign ev_tot       = head.tot;
  assign ev_sat       = head.sat;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_tot_event_capture.sv
// tb/tb_tot_event_capture.sv - bench for tot_event_capture
// Drives a 16-bit and a 4-bit instance with shared directed stimulus and checks both against a queue model every cycle.
module tb_tot_event_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, ts_clear = 1'b0, rise = 1'b0, fall = 1'b0, ev_ready = 1'b0;

  always #5 clk = ~clk;

  logic        v16, s16, v4, s4;
  logic [15:0] ts16, tot16;
  logic [3:0]  ts4, tot4, lvl16, lvl4;
  logic [7:0]  dr16, dr4;

  tot_event_capture #(.TS_WIDTH(16), .FIFO_DEPTH(8)) u16 (
    .clk(clk), .rst(rst), .enable(enable), .ts_clear(ts_clear),
    .rising_edge(rise), .falling_edge(fall), .ev_valid(v16), .ev_ready(ev_ready),
    .ev_timestamp(ts16), .ev_tot(tot16), .ev_sat(s16), .fifo_level(lvl16), .drop_count(dr16)
  );

  tot_event_capture #(.TS_WIDTH(4), .FIFO_DEPTH(8)) u4 (
    .clk(clk), .rst(rst), .enable(enable), .ts_clear(ts_clear),
    .rising_edge(rise), .falling_edge(fall), .ev_valid(v4), .ev_ready(ev_ready),
    .ev_timestamp(ts4), .ev_tot(tot4), .ev_sat(s4), .fifo_level(lvl4), .drop_count(dr4)
  );

`ifdef TOT_EVENT_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  localparam int unsigned MX [2] = '{32'd65535, 32'd15};

  typedef struct {
    int unsigned ts;
    int unsigned tot;
    bit          sat;
  } ev_s;

  ev_s         mq [2][$];
  bit          meas [2];
  bit          waitf [2];
  int unsigned st_cyc [2];
  int unsigned st_ts [2];
  int unsigned tsm [2];
  int unsigned dropm [2];
  int unsigned cyc;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a measurement is just (start cycle, start stamp); ToT is the cycle difference.
  task automatic step(input int k);
    bit ro, fo, pu;
    ev_s e;
    int unsigned d;
    ro = rise && !fall;
    fo = fall && !rise;
    pu = 1'b0;
    e  = '{0, 0, 1'b0};
    if (!enable) begin
      meas[k]  = 1'b0;
      waitf[k] = 1'b0;
    end else if (meas[k]) begin
      d = cyc - st_cyc[k];
      if (TMO && d == MX[k]) begin
        e = '{st_ts[k], MX[k], 1'b1};
        pu = 1'b1;
        meas[k] = 1'b0;
        waitf[k] = !fo;
      end else if (fo) begin
        e = '{st_ts[k], (d > MX[k]) ? MX[k] : d, d >= MX[k]};
        pu = 1'b1;
        meas[k] = 1'b0;
      end
    end else if (waitf[k]) begin
      if (fo) waitf[k] = 1'b0;
    end else if (ro) begin
      meas[k]   = 1'b1;
      st_cyc[k] = cyc;
      st_ts[k]  = tsm[k];
    end
    if (mq[k].size() > 0 && ev_ready) void'(mq[k].pop_front());
    if (pu) begin
      if (mq[k].size() < 8) mq[k].push_back(e);
      else if (dropm[k] < 255) dropm[k]++;
    end
    tsm[k] = ts_clear ? 0 : (tsm[k] + 1) % (MX[k] + 1);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        meas[k] = 1'b0; waitf[k] = 1'b0; tsm[k] = 0; dropm[k] = 0;
        st_cyc[k] = 0; st_ts[k] = 0;
      end
      cyc = 0;
    end else begin
      for (int k = 0; k < 2; k++) step(k);
      cyc++;
    end
  end

  task automatic cmp(input int k, input logic v, input int unsigned ts, input int unsigned tot,
                     input logic sat, input int unsigned lvl, input int unsigned dr);
    string p;
    p = (k == 0) ? "w16" : "w4";
    if (rst) begin
      chk({p, "_rst_valid"}, v, 0);
      chk({p, "_rst_level"}, lvl, 0);
      chk({p, "_rst_drop"}, dr, 0);
      chk({p, "_rst_ts"}, ts, 0);
      chk({p, "_rst_tot"}, tot, 0);
      chk({p, "_rst_sat"}, sat, 0);
    end else begin
      chk({p, "_valid"}, v, mq[k].size() != 0);
      chk({p, "_level"}, lvl, mq[k].size());
      chk({p, "_drop"}, dr, dropm[k]);
      if (mq[k].size() != 0) begin
        chk({p, "_timestamp"}, ts, mq[k][0].ts);
        chk({p, "_tot"}, tot, mq[k][0].tot);
        chk({p, "_sat"}, sat, mq[k][0].sat);
      end
    end
  endtask

  always @(negedge clk) begin
    cmp(0, v16, 32'(ts16), 32'(tot16), s16, 32'(lvl16), 32'(dr16));
    cmp(1, v4, 32'(ts4), 32'(tot4), s4, 32'(lvl4), 32'(dr4));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int gap);
    rise = 1'b1; tick(); rise = 1'b0;
    repeat (gap - 1) tick();
    fall = 1'b1; tick(); fall = 1'b0;
  endtask

  task automatic drain(input int n);
    ev_ready = 1'b1;
    repeat (n) tick();
    ev_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    enable = 1'b1;

    // Rising at ts=10, falling 5 cycles later.
    ts_clear = 1'b1; tick(); ts_clear = 1'b0;
    repeat (10) tick();
    rise = 1'b1; tick(); rise = 1'b0;
    repeat (4) tick();
    chk("t1_valid_before", v16, 0);
    fall = 1'b1; tick(); fall = 1'b0;
    chk("t1_valid_after", v16, 1);
    chk("t1_ts16", ts16, 10);
    chk("t1_tot16", tot16, 5);
    chk("t1_sat16", s16, 0);
    chk("t1_ts4", ts4, 10);
    chk("t1_tot4", tot4, 5);
    chk("t1_model_size", mq[0].size(), 1);
    chk("t1_model_ts", mq[0][0].ts, 10);
    chk("t1_model_tot", mq[0][0].tot, 5);
    drain(2);

    // Nine pulses into an 8-deep FIFO with no readout.
    repeat (9) begin pulse(3); tick(); end
    chk("t2_level16", lvl16, 8);
    chk("t2_drop16", dr16, 1);
    chk("t2_level4", lvl4, 8);
    chk("t2_drop4", dr4, 1);
    chk("t2_model_drop", dropm[0], 1);
    drain(9);
    chk("t2_level_drained", lvl16, 0);

    // Full FIFO, push and pop in the same cycle.
    repeat (8) begin pulse(2); tick(); end
    rise = 1'b1; tick(); rise = 1'b0;
    tick();
    fall = 1'b1; ev_ready = 1'b1; tick(); fall = 1'b0; ev_ready = 1'b0;
    chk("t3_level16", lvl16, 8);
    chk("t3_drop16", dr16, 1);
    chk("t3_level4", lvl4, 8);
    drain(9);

    // Enable dropped mid-measurement.
    rise = 1'b1; tick(); rise = 1'b0;
    enable = 1'b0; tick(); enable = 1'b1;
    tick();
    fall = 1'b1; tick(); fall = 1'b0;
    tick();
    chk("t4_level16", lvl16, 0);
    chk("t4_level4", lvl4, 0);
    pulse(4); tick();
    chk("t4_after_tot16", tot16, 4);
    drain(2);

    // Simultaneous pulses, lone falling, second rising in HIGH.
    rise = 1'b1; fall = 1'b1; tick(); rise = 1'b0; fall = 1'b0;
    tick();
    fall = 1'b1; tick(); fall = 1'b0;
    tick();
    chk("t5_no_spurious", lvl16, 0);
    rise = 1'b1; tick(); rise = 1'b0;
    tick();
    rise = 1'b1; tick(); rise = 1'b0;
    tick(); tick();
    fall = 1'b1; tick(); fall = 1'b0;
    chk("t5_level16", lvl16, 1);
    chk("t5_tot16", tot16, 5);
    chk("t5_tot4", tot4, 5);
    drain(2);

    // Long pulse: 4-bit instance saturates.
    pulse(20);
    tick();
    chk("t6_level4", lvl4, 1);
    chk("t6_tot4", tot4, 15);
    chk("t6_sat4", s4, 1);
    chk("t6_tot16", tot16, 20);
    chk("t6_sat16", s16, 0);
    drain(2);

    // Timestamp wrap on the 4-bit instance.
    ts_clear = 1'b1; tick(); ts_clear = 1'b0;
    repeat (17) tick();
    pulse(2);
    chk("t7_ts4_wrapped", ts4, 1);
    chk("t7_ts16", ts16, 17);
    drain(2);

    // Reset during measurement and with events buffered.
    repeat (3) begin pulse(2); end
    rise = 1'b1; tick(); rise = 1'b0;
    rst = 1'b1; #1;
    chk("t8_valid_in_rst", v16, 0);
    chk("t8_level_in_rst", lvl16, 0);
    tick(); tick();
    rst = 1'b0;
    fall = 1'b1; tick(); fall = 1'b0;
    chk("t8_no_stale_event", lvl16, 0);
    pulse(3); tick();
    chk("t8_after_tot16", tot16, 3);
    drain(2);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/tot_event_capture.md
# tot_event_capture

Consumes the single-cycle `rising_edge` / `falling_edge` pulses produced by the edge-detection stage. Measures each pulse's time-over-threshold (ToT) in clock cycles and timestamps its rising edge against a free-running counter. Buffers completed events in a small show-ahead FIFO with a valid/ready readout port for the readout/packetiser stage.

## Interface
Parameters:
- `TS_WIDTH`, 16: width of the timestamp counter and the ToT field.
- `FIFO_DEPTH`, 8: event buffer depth; must be a power of two and at least 2.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: capture enable; the FIFO stays readable when this is low.
- `ts_clear`, in, 1: synchronous clear of the timestamp counter.
- `rising_edge`, in, 1: single-cycle pulse from the edge detector.
- `falling_edge`, in, 1: single-cycle pulse from the edge detector.
- `ev_valid`, out, 1: the FIFO head holds an event.
- `ev_ready`, in, 1: consumer accepts the head event.
- `ev_timestamp`, out, TS_WIDTH: timestamp of the rising edge.
- `ev_tot`, out, TS_WIDTH: ToT in cycles.
- `ev_sat`, out, 1: ToT saturated or timed out.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `drop_count`, out, 8: events lost because the FIFO was full; saturates.

## Operation
- Timestamp counter `ts`:
  - increments every cycle and wraps modulo 2^TS_WIDTH;
  - `ts_clear` loads it with 0, taking priority over the increment.
- FSM states: IDLE, HIGH, WAIT_FALL. WAIT_FALL exists only with the macro defined.
- IDLE:
  - `rising_edge & ~falling_edge & enable` latches the current `ts` as the start stamp, clears the ToT counter, and moves to HIGH;
  - a `falling_edge` pulse is ignored.
- HIGH:
  - the ToT counter increments each cycle, saturating at 2^TS_WIDTH−1;
  - on `falling_edge`: push {start stamp, ToT, sat}, then go to IDLE;
  - pushed ToT = f − r, where r is the rising cycle and f the falling cycle (minimum 1); sat = 1 if the value saturated;
  - a `rising_edge` pulse in HIGH (lost falling edge) is ignored and the measurement continues.
- Both pulses asserted in the same cycle: ignored in every state.
- `enable` low: the FSM goes to IDLE next cycle, any in-progress measurement is discarded, and no push occurs.
- FIFO:
  - push succeeds if not full, or if full with a pop in the same cycle;
  - otherwise the event is dropped and `drop_count` increments, saturating at 255;
  - pop occurs on `ev_valid & ev_ready`;
  - `ev_*` outputs show the head entry and are don't-care while `ev_valid` = 0.

## Timing
- Reset values: FSM IDLE, `ts` = 0, `ev_valid` = 0, `fifo_level` = 0, `drop_count` = 0; `ev_timestamp`, `ev_tot` and `ev_sat` = 0.
- Latency: with the FIFO empty, a `falling_edge` in cycle f gives `ev_valid` = 1 in cycle f+1.
- The head is stable while `ev_valid & ~ev_ready`.
- `fifo_level` updates the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full is `fifo_level == FIFO_DEPTH`; empty is `fifo_level == 0`.
- `rst` asserted mid-measurement or mid-readout discards all state immediately.

## Configuration
- Macro `TOT_EVENT_TIMEOUT_EN`.
- Defined:
  - when the ToT counter reaches 2^TS_WIDTH−1 in HIGH, push the event with `ev_sat` = 1 in that cycle and go to WAIT_FALL;
  - WAIT_FALL ignores `rising_edge`, returns to IDLE on `falling_edge` or `~enable`, and pushes nothing.
- Undefined: the ToT counter saturates and waits for `falling_edge`; `ev_sat` = 1 on that event.

## Structure
- `tot_event_pkg`:
  - `tot_state_e` enum (IDLE, HIGH, WAIT_FALL);
  - `tot_event_t` packed struct {sat, tot, timestamp} parameterised via package localparam default TS_WIDTH;
  - DROP_CNT_WIDTH = 8.
- Sub-module `tot_event_fifo`: a synchronous show-ahead FIFO that stores `tot_event_t`, with push, pop, level and full outputs.

## Test plan
- Reset release, rising at ts=10, falling 5 cycles later -> one event {timestamp=10, tot=5, sat=0}; `ev_valid` high the cycle after falling.
- 9 pulses with `ev_ready` = 0, FIFO_DEPTH = 8 -> `fifo_level` = 8, `drop_count` = 1; draining yields the first 8 events in order.
- With the FIFO full, a push and a pop in the same cycle -> no drop, `fifo_level` stays 8, and the new event arrives last.
- Rising pulse, then `enable` low for 1 cycle, then falling -> no event pushed, FSM back in IDLE.
- Simultaneous rising and falling in IDLE; a lone falling in IDLE; a second rising in HIGH -> ToT measured from the first rising only, no spurious events.
- TS_WIDTH = 4 and a pulse longer than 15 cycles:
  - with macro -> {tot=15, sat=1} pushed at saturation, nothing at falling;
  - without macro -> {tot=15, sat=1} pushed at falling.
  - Also check that `ts` wraps from 15 to 0.
